// File: rtl/selector_rr_n.sv
// N-way WIDTH-bit request selector, round-robin or fixed priority, with a registered output word.
// Latency: one cycle from the grant (oGnt) to the word on oZ with oValid high.
// Backpressure: iReady low while oValid is high stalls the stage; no grant is issued and all state holds.
module selector_rr_n #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int SEL_W = $clog2(NUM)
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [NUM-1:0]       iReq,
    input  logic [NUM*WIDTH-1:0] iData,
    input  logic                 iMode,
    input  logic                 iReady,
    output logic [NUM-1:0]       oGnt,
    output logic [WIDTH-1:0]     oZ,
    output logic [SEL_W-1:0]     oSel,
    output logic                 oValid
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             win_vld;
    logic [SEL_W-1:0] win_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] win_dat;

    // The output register may take a new word when it is empty or being drained this cycle.
    assign accept  = !valid_q || iReady;
    assign gnt_vld = accept && win_vld && !iRst;

    // Winner search: start at ptr (round-robin) or 0 (fixed priority), ascending with wrap.
    always_comb begin
        int start;
        int c;
        win_vld = 1'b0;
        win_idx = '0;
        start   = iMode ? 0 : int'(ptr_q);
        c       = 0;
        for (int i = 0; i < NUM; i++) begin
            c = start + i;
            if (c >= NUM) begin
                c = c - NUM;
            end
            if (!win_vld && iReq[c]) begin
                win_vld = 1'b1;
                win_idx = SEL_W'(c);
            end
        end
    end

    // Only the winning lane is routed, so idle lanes never reach oZ.
    assign win_dat = iData[int'(win_idx)*WIDTH +: WIDTH];

    // One-hot grant, suppressed during reset and when the output stage is stalled.
    always_comb begin
        oGnt = '0;
        if (gnt_vld) begin
            oGnt[win_idx] = 1'b1;
        end
    end

    // Next-state for the output word and the round-robin pointer.
    always_comb begin
        ptr_d   = ptr_q;
        z_d     = z_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (gnt_vld) begin
            z_d     = win_dat;
            sel_d   = win_idx;
            valid_d = 1'b1;
            if (!iMode) begin
                ptr_d = (win_idx == SEL_W'(NUM-1)) ? '0 : win_idx + 1'b1;
            end
        end else if (accept) begin
            // Drained with nothing to replace it; data and index keep their last values.
            valid_d = 1'b0;
        end
    end

    // State registers; reset clears the held word immediately, without waiting for an edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ptr_q   <= '0;
            z_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            z_q     <= z_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign oZ     = z_q;
    assign oSel   = sel_q;
    assign oValid = valid_q;

endmodule

// File: doc/selector_rr_n.md
Name: selector_rr_n

Overview:
- Parametrised N-way, WIDTH-bit successor to the CPU's 2:1 datapath selectors.
- Each cycle it picks one requesting channel, round-robin or fixed priority, and captures that channel's data in a registered output stage.
- The output stage uses a valid/ready handshake.
- Used where several producers share one consumer port, e.g. writeback sources or memory-request ports.

Parameters:
- WIDTH, 32: data width per channel.
- NUM, 4: number of input channels, must be at least 2; need not be a power of two.
- SEL_W, $clog2(NUM): width of the channel index.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iReq  input  NUM  per-channel request; bit k = channel k has valid data.
- iData  input  NUM*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- iMode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- iReady  input  1  consumer accepts oZ this cycle.
- oGnt  output  NUM  one-hot, combinational; bit k high = channel k captured at the next edge.
- oZ  output  WIDTH  registered selected data.
- oSel  output  SEL_W  registered index of the channel held in oZ.
- oValid  output  1  oZ/oSel hold an unconsumed word.

Behaviour:
- Reset (asynchronous, iRst=1):
  - oZ=0, oSel=0, oValid=0.
  - Internal round-robin pointer ptr=0.
  - oGnt=0 while iRst is high.
- Capture enable: accept = !oValid || iReady. A one-entry output register gives full throughput of one word per cycle.
- Arbitration, evaluated combinationally every cycle:
  - Round-robin (iMode=0): search iReq starting at index ptr, ascending, wrapping NUM-1 -> 0. The first set bit wins.
  - Fixed priority (iMode=1): the lowest set index wins. ptr is ignored and not updated.
- oGnt = one-hot(winner) when accept && |iReq; otherwise 0.
- On an edge with a grant:
  - oZ <= iData[winner].
  - oSel <= winner.
  - oValid <= 1.
  - If iMode=0: ptr <= (winner==NUM-1) ? 0 : winner+1.
- On an edge with accept and no request: oValid <= 0. oZ and oSel hold their last values.
- Stall (oValid && !iReady): oGnt=0. oZ, oSel, oValid and ptr all hold.
- Latency: one cycle from grant to the word appearing on oZ with oValid=1.
- Producer rule: a producer holds iReq and iData stable until it sees its oGnt bit high. It may drop or change iReq/iData in the cycle after the grant.
- Simultaneous consume and capture (oValid && iReady && |iReq): the old word is consumed and the new word is captured in the same edge. oValid stays 1.
- Mode switch: takes effect in the same cycle's arbitration. ptr keeps its value across fixed-priority periods.
- Reset asserted mid-transfer: the word is discarded, oValid drops immediately, ptr returns to 0.
- X-free: iData lanes of non-requesting channels never propagate to oZ.

Test Plan:
1. Reset, then hold iReq=0:
   - oValid=0, oZ=0, oSel=0, oGnt=0 for 5 cycles.
2. Round-robin fairness: NUM=4, iMode=0, iReady=1, iReq=4'b1111 held, iData lanes = 0xA0,0xA1,0xA2,0xA3:
   - oGnt sequence 0001,0010,0100,1000,0001.
   - oSel one cycle later: 0,1,2,3,0.
   - oZ: 0xA0,0xA1,0xA2,0xA3,0xA0.
3. Wrap / skip: ptr=3 (after granting channel 2), iReq=4'b0011:
   - Grant goes to channel 0 (wrap), then to channel 1.
   - ptr ends at 2.
4. Backpressure:
   - Capture 0x55 from channel 1, then drive iReady=0 for 3 cycles with iReq=4'b0100.
   - Required: oZ=0x55, oValid=1, oGnt=0 throughout.
   - Raise iReady: oGnt=0100 in the same cycle, oZ=ch2 data on the next edge, oValid continuously 1.
5. Fixed priority: iMode=1, iReq=4'b1010 held, iReady=1:
   - Channel 1 is granted every cycle; channel 3 is never granted.
   - Switch to iMode=0: the next grant follows the ptr value held before fixed mode.
6. Async reset mid-stream: assert iRst between clock edges while oValid=1:
   - oValid=0, oZ=0 immediately, without waiting for an edge.
   - After release, the first round-robin grant with iReq=4'b1111 goes to channel 0.
